mem_stage: RTL and testbench

//  MEM stage of the 64-bit RISC-V pipeline. Sits between the EX/MEM pipeline

---
 rtl/mem_stage.sv | 204 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM stage of the 64-bit RISC-V pipeline: branch resolution, little-endian
// byte-addressed data memory sized by funct3, a multi-cycle access sequencer
// that stalls upstream, and the MEM/WB pipeline register.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no access in flight; a memory op either completes now
//        | (MEM_LATENCY==1) or starts a multi-cycle access
// ACCESS | multi-cycle access in flight; cnt_q counts elapsed cycles,
//        | completion happens when cnt_q reaches MEM_LATENCY-1
`timescale 1ns/1ps
module mem_stage #(
    parameter int DEPTH       = 256,
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite_in,
    input  logic        MemtoReg_in,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [63:0] branch_add,
    input  logic [63:0] ALU_result,
    input  logic [63:0] WriteData,
    input  logic [3:0]  funct_in,
    input  logic [4:0]  rd,
    output logic        PCSrc,
    output logic [63:0] branch_target,
    output logic        stall,
    output logic        mem_fault,
    output logic        RegWrite_out,
    output logic        MemtoReg_out,
    output logic [63:0] ReadData,
    output logic [63:0] ALU_result_out,
    output logic [4:0]  rd_out
);

    localparam int            AW       = $clog2(DEPTH);
    localparam int            CW       = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY - 1);
    localparam bit            MULTI    = (MEM_LATENCY > 1);

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    mem_q [DEPTH];

    logic          regwrite_q, memtoreg_q, fault_q;
    logic [63:0]   readdata_q, alu_q;
    logic [4:0]    rd_q;

    logic          regwrite_d, memtoreg_d, fault_d;
    logic [63:0]   readdata_d, alu_d;
    logic [4:0]    rd_d;

    logic [2:0]    funct3;
    logic          unused_funct7;
    logic          mem_op, is_load, taken;
    logic [3:0]    size_bytes;
    logic          misaligned, out_of_range, bad_funct, fault;
    logic          stall_c, wr_en;
    logic [AW-1:0] addr_idx;
    logic [63:0]   raw, load_val;

    assign funct3        = funct_in[2:0];
    assign unused_funct7 = funct_in[3];
    assign mem_op        = MemRead | MemWrite;
    // MemWrite wins when both are requested, so such an op is never a load
    assign is_load       = MemRead & ~MemWrite;
    assign addr_idx      = ALU_result[AW-1:0];

    // Branch decision: only bne inverts the zero flag
    always_comb begin
        taken = (funct3 == 3'b001) ? ~Zero : Zero;
    end

    assign PCSrc         = Branch & taken;
    assign branch_target = branch_add;

    // Access size, alignment and range checks
    always_comb begin
        size_bytes = 4'd1 << funct3[1:0];
        case (funct3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = ALU_result[0];
            2'b10:   misaligned = |ALU_result[1:0];
            default: misaligned = |ALU_result[2:0];
        endcase
        out_of_range = ({1'b0, ALU_result} + 65'(size_bytes)) > 65'(DEPTH);
        // stores have no unsigned variants; loads have no 111 encoding
        bad_funct    = MemWrite ? funct3[2] : (funct3 == 3'b111);
        fault        = mem_op & (misaligned | out_of_range | bad_funct);
    end

    // Stall request; held low in reset so upstream is not frozen by stale inputs
    always_comb begin
        stall_c = 1'b0;
        if (reset) begin
            if (state_q == S_ACCESS) begin
                stall_c = (cnt_q != CNT_LAST);
            end else begin
                stall_c = mem_op && MULTI;
            end
        end
    end

    assign stall = stall_c;
    assign wr_en = reset & MemWrite & ~fault & ~stall_c;

    // Gather eight bytes from the access address, then size and extend
    always_comb begin
        raw = '0;
        for (int i = 0; i < 8; i++) begin
            raw[8*i +: 8] = mem_q[addr_idx + AW'(i)];
        end
        case (funct3)
            3'b000:  load_val = {{56{raw[7]}}, raw[7:0]};
            3'b001:  load_val = {{48{raw[15]}}, raw[15:0]};
            3'b010:  load_val = {{32{raw[31]}}, raw[31:0]};
            3'b011:  load_val = raw;
            3'b100:  load_val = {56'd0, raw[7:0]};
            3'b101:  load_val = {48'd0, raw[15:0]};
            3'b110:  load_val = {32'd0, raw[31:0]};
            default: load_val = '0;
        endcase
    end

    // Byte-lane store on the completion edge; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) < size_bytes) begin
                    mem_q[addr_idx + AW'(i)] <= WriteData[8*i +: 8];
                end
            end
        end
    end

    // MEM/WB next value: bubble while stalled, faulted ops never write back
    always_comb begin
        regwrite_d = 1'b0;
        memtoreg_d = 1'b0;
        readdata_d = '0;
        alu_d      = '0;
        rd_d       = '0;
        fault_d    = 1'b0;
        if (!stall_c) begin
            regwrite_d = RegWrite_in & ~fault;
            memtoreg_d = MemtoReg_in;
            readdata_d = (is_load && !fault) ? load_val : '0;
            alu_d      = ALU_result;
            rd_d       = rd;
            fault_d    = fault;
        end
    end

    // Access sequencer and MEM/WB register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            readdata_q <= '0;
            alu_q      <= '0;
            rd_q       <= '0;
            fault_q    <= 1'b0;
        end else begin
            if (state_q == S_IDLE) begin
                if (mem_op && MULTI) begin
                    state_q <= S_ACCESS;
                    cnt_q   <= CW'(1);
                end
            end else begin
                if (cnt_q == CNT_LAST) begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            readdata_q <= readdata_d;
            alu_q      <= alu_d;
            rd_q       <= rd_d;
            fault_q    <= fault_d;
        end
    end

    assign RegWrite_out   = regwrite_q;
    assign MemtoReg_out   = memtoreg_q;
    assign ReadData       = readdata_q;
    assign ALU_result_out = alu_q;
    assign rd_out         = rd_q;
    assign mem_fault      = fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: one instance with single-cycle memory, one with a
// three-cycle memory. Drivers queue expected MEM/WB contents; a monitor pops
// them on every non-stalled edge and checks bubbles on stalled edges.
`timescale 1ns/1ps
module tb_mem_stage;

    localparam int DEPTH = 256;

    typedef struct packed {
        logic        regwrite;
        logic        memtoreg;
        logic        branch;
        logic        zero;
        logic        memwrite;
        logic        memread;
        logic [63:0] badd;
        logic [63:0] alu;
        logic [63:0] wdata;
        logic [3:0]  funct;
        logic [4:0]  rd;
    } in_t;

    typedef struct packed {
        logic        regwrite;
        logic        memtoreg;
        logic [63:0] rdata;
        logic [63:0] alu;
        logic [4:0]  rd;
        logic        fault;
    } res_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    in_t  in1, in3;
    res_t o1, o3;
    res_t q1[$];
    res_t q3[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic        pc1, pc3, st1, st3, flt1, flt3, rw1, rw3, mt1, mt3;
    logic [63:0] bt1, bt3, rdat1, rdat3, alu1, alu3;
    logic [4:0]  rdo1, rdo3;

    always #5 clk = ~clk;

    mem_stage #(.DEPTH(DEPTH), .MEM_LATENCY(1)) u_lat1 (
        .clk(clk), .reset(reset),
        .RegWrite_in(in1.regwrite), .MemtoReg_in(in1.memtoreg),
        .Branch(in1.branch), .Zero(in1.zero),
        .MemWrite(in1.memwrite), .MemRead(in1.memread),
        .branch_add(in1.badd), .ALU_result(in1.alu), .WriteData(in1.wdata),
        .funct_in(in1.funct), .rd(in1.rd),
        .PCSrc(pc1), .branch_target(bt1), .stall(st1), .mem_fault(flt1),
        .RegWrite_out(rw1), .MemtoReg_out(mt1), .ReadData(rdat1),
        .ALU_result_out(alu1), .rd_out(rdo1)
    );

    mem_stage #(.DEPTH(DEPTH), .MEM_LATENCY(3)) u_lat3 (
        .clk(clk), .reset(reset),
        .RegWrite_in(in3.regwrite), .MemtoReg_in(in3.memtoreg),
        .Branch(in3.branch), .Zero(in3.zero),
        .MemWrite(in3.memwrite), .MemRead(in3.memread),
        .branch_add(in3.badd), .ALU_result(in3.alu), .WriteData(in3.wdata),
        .funct_in(in3.funct), .rd(in3.rd),
        .PCSrc(pc3), .branch_target(bt3), .stall(st3), .mem_fault(flt3),
        .RegWrite_out(rw3), .MemtoReg_out(mt3), .ReadData(rdat3),
        .ALU_result_out(alu3), .rd_out(rdo3)
    );

    assign o1 = {rw1, mt1, rdat1, alu1, rdo1, flt1};
    assign o3 = {rw3, mt3, rdat3, alu3, rdo3, flt3};

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic chk_res(input string name, input res_t got, input res_t want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got rw=%0b mt=%0b rdata=%h alu=%h rd=%0d flt=%0b want rw=%0b mt=%0b rdata=%h alu=%h rd=%0d flt=%0b",
                     name, got.regwrite, got.memtoreg, got.rdata, got.alu, got.rd, got.fault,
                     want.regwrite, want.memtoreg, want.rdata, want.alu, want.rd, want.fault);
        end
    endtask

    task automatic chk_bubble(input string name, input res_t got);
        n_cmp++;
        if ({got.regwrite, got.memtoreg, got.rd, got.fault} !== 8'd0) begin
            n_bad++;
            $display("FAIL %s: got rw=%0b mt=%0b rd=%0d flt=%0b want all 0",
                     name, got.regwrite, got.memtoreg, got.rd, got.fault);
        end
    endtask

    // Monitor: a non-stalled, non-reset edge with a queued op produces a result
    bit   pend1 = 0, pend3 = 0, bub1 = 0, bub3 = 0;
    res_t e1, e3;
    always @(negedge clk) begin
        if (pend1) begin
            e1 = q1.pop_front();
            chk_res("lat1 result", o1, e1);
        end else if (bub1) begin
            chk_bubble("lat1 bubble", o1);
        end
        if (pend3) begin
            e3 = q3.pop_front();
            chk_res("lat3 result", o3, e3);
        end else if (bub3) begin
            chk_bubble("lat3 bubble", o3);
        end
        pend1 = reset && !st1 && (q1.size() > 0);
        bub1  = reset && st1;
        pend3 = reset && !st3 && (q3.size() > 0);
        bub3  = reset && st3;
    end

    task automatic issue(input bit w3, input in_t v, input res_t e, input logic exp_pc);
        int stalls;
        int want_stalls;
        @(posedge clk);
        #1;
        if (w3) begin
            in3 = v;
            q3.push_back(e);
        end else begin
            in1 = v;
            q1.push_back(e);
        end
        want_stalls = ((v.memread || v.memwrite) && w3) ? 2 : 0;
        @(negedge clk);
        chk(w3 ? "lat3 PCSrc" : "lat1 PCSrc", 64'(w3 ? pc3 : pc1), 64'(exp_pc));
        chk(w3 ? "lat3 branch_target" : "lat1 branch_target", w3 ? bt3 : bt1, v.badd);
        stalls = 0;
        while ((w3 ? st3 : st1) && stalls < 8) begin
            stalls++;
            @(negedge clk);
        end
        chk(w3 ? "lat3 stall cycles" : "lat1 stall cycles", 64'(stalls), 64'(want_stalls));
    endtask

    task automatic do_ld(input bit w3, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [4:0] rdn, input logic [63:0] data, input logic flt);
        in_t  v;
        res_t e;
        v = '0;
        e = '0;
        v.memread  = 1'b1;
        v.memtoreg = 1'b1;
        v.regwrite = 1'b1;
        v.alu      = addr;
        v.funct    = {1'b0, f3};
        v.rd       = rdn;
        e.regwrite = ~flt;
        e.memtoreg = 1'b1;
        e.rdata    = data;
        e.alu      = addr;
        e.rd       = rdn;
        e.fault    = flt;
        issue(w3, v, e, 1'b0);
    endtask

    task automatic do_st(input bit w3, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] data, input logic also_rd, input logic flt);
        in_t  v;
        res_t e;
        v = '0;
        e = '0;
        v.memwrite = 1'b1;
        v.memread  = also_rd;
        v.alu      = addr;
        v.wdata    = data;
        v.funct    = {1'b0, f3};
        e.alu      = addr;
        e.fault    = flt;
        issue(w3, v, e, 1'b0);
    endtask

    task automatic do_br(input bit w3, input logic [2:0] f3, input logic zero,
                         input logic [63:0] badd, input logic exp_pc);
        in_t  v;
        res_t e;
        v = '0;
        e = '0;
        v.branch = 1'b1;
        v.zero   = zero;
        v.badd   = badd;
        v.funct  = {1'b0, f3};
        issue(w3, v, e, exp_pc);
    endtask

    task automatic do_alu(input bit w3, input logic [63:0] val, input logic [4:0] rdn);
        in_t  v;
        res_t e;
        v = '0;
        e = '0;
        v.regwrite = 1'b1;
        v.alu      = val;
        v.rd       = rdn;
        e.regwrite = 1'b1;
        e.alu      = val;
        e.rd       = rdn;
        issue(w3, v, e, 1'b0);
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        in1 = '0;
        in3 = '0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [223:0] rnd;
        in_t          abort_sd;

        // Reset with random inputs, memory op forced on the stalling instance
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 7; k++) rnd[32*k +: 32] = $urandom;
            in1 = rnd[$bits(in_t)-1:0];
            for (int k = 0; k < 7; k++) rnd[32*k +: 32] = $urandom;
            in3 = rnd[$bits(in_t)-1:0];
            in3.memread = 1'b1;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk_res("reset lat1 outputs", o1, '0);
        chk_res("reset lat3 outputs", o3, '0);
        chk("reset lat1 stall", 64'(st1), 64'd0);
        chk("reset lat3 stall", 64'(st3), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        in1   = '0;
        in3   = '0;

        // Single-cycle memory: store then sized loads
        do_st (0, 3'b011, 64'h10, 64'h8877665544332211, 1'b0, 1'b0);
        do_ld (0, 3'b000, 64'h17, 5'd5,  64'hFFFF_FFFF_FFFF_FF88, 1'b0);
        do_ld (0, 3'b100, 64'h17, 5'd6,  64'h0000_0000_0000_0088, 1'b0);
        do_ld (0, 3'b010, 64'h14, 5'd7,  64'hFFFF_FFFF_8877_6655, 1'b0);
        do_ld (0, 3'b101, 64'h12, 5'd8,  64'h0000_0000_0000_4433, 1'b0);
        do_ld (0, 3'b001, 64'h16, 5'd9,  64'hFFFF_FFFF_FFFF_8877, 1'b0);
        do_ld (0, 3'b110, 64'h14, 5'd10, 64'h0000_0000_8877_6655, 1'b0);
        do_ld (0, 3'b011, 64'h10, 5'd11, 64'h8877_6655_4433_2211, 1'b0);
        do_alu(0, 64'hDEAD_BEEF, 5'd12);
        do_st (0, 3'b000, 64'h18, 64'h1234_5678_9ABC_DEAB, 1'b1, 1'b0);
        do_ld (0, 3'b100, 64'h18, 5'd13, 64'h0000_0000_0000_00AB, 1'b0);

        // Faults and range boundaries
        do_ld (0, 3'b010, 64'h12, 5'd14, 64'h0, 1'b1);
        do_st (0, 3'b010, 64'hFC, 64'hAAAA_AAAA_1122_3344, 1'b0, 1'b0);
        do_st (0, 3'b011, 64'hFC, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        do_ld (0, 3'b110, 64'hFC, 5'd15, 64'h0000_0000_1122_3344, 1'b0);
        do_ld (0, 3'b100, 64'hFF, 5'd16, 64'h0000_0000_0000_0011, 1'b0);
        do_st (0, 3'b011, 64'h100, 64'h5555_5555_5555_5555, 1'b0, 1'b1);
        do_st (0, 3'b100, 64'h18, 64'h0000_0000_0000_00FF, 1'b0, 1'b1);
        do_ld (0, 3'b100, 64'h18, 5'd17, 64'h0000_0000_0000_00AB, 1'b0);

        // Branch resolution
        do_br (0, 3'b001, 1'b0, 64'h400, 1'b1);
        do_br (0, 3'b001, 1'b1, 64'h400, 1'b0);
        do_br (0, 3'b000, 1'b1, 64'h404, 1'b1);
        do_br (0, 3'b000, 1'b0, 64'h404, 1'b0);
        do_br (0, 3'b100, 1'b1, 64'h800, 1'b1);
        idle(2);

        // Three-cycle memory: back-to-back ops, passthrough, fault
        do_st (1, 3'b011, 64'h10, 64'h8877665544332211, 1'b0, 1'b0);
        do_ld (1, 3'b011, 64'h10, 5'd9, 64'h8877_6655_4433_2211, 1'b0);
        do_ld (1, 3'b010, 64'h14, 5'd3, 64'hFFFF_FFFF_8877_6655, 1'b0);
        do_ld (1, 3'b100, 64'h17, 5'd4, 64'h0000_0000_0000_0088, 1'b0);
        do_alu(1, 64'h55, 5'd2);
        do_ld (1, 3'b010, 64'h12, 5'd5, 64'h0, 1'b1);
        do_st (1, 3'b011, 64'h20, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);

        // Reset in the middle of a store aborts it
        abort_sd          = '0;
        abort_sd.memwrite = 1'b1;
        abort_sd.alu      = 64'h20;
        abort_sd.wdata    = 64'hFFFF_FFFF_FFFF_FFFF;
        abort_sd.funct    = 4'b0011;
        @(posedge clk);
        #1;
        in3 = abort_sd;
        @(negedge clk);
        chk("abort store stall", 64'(st3), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        in3   = '0;
        in1   = '0;
        @(negedge clk);
        chk_res("abort lat3 outputs", o3, '0);
        chk("abort lat3 stall", 64'(st3), 64'd0);
        do_ld (1, 3'b011, 64'h20, 5'd20, 64'h0123_4567_89AB_CDEF, 1'b0);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
